// File: rtl/vscale_mem_responder.sv
// vscale_mem_responder: dual-port memory responder for the vscale core.
// It is the slave end of the imem and dmem buses. Each port uses a pipelined
// address-phase / data-phase handshake with a fixed number of wait states.
// Both ports share one WORDS x 32 array.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_addr                   fetch byte address (an address phase every cycle)
//   imem_rdata/wait/badmem_e    fetch data, data-phase stall, fetch error
//   dmem_en/wen/size/addr       data address phase (size = RV32 funct3)
//   dmem_wdata_delayed          store data, LSB-aligned, valid in the data phase
//   dmem_rdata/wait/badmem_e    load data (extended), data-phase stall, error
//
// All outputs depend only on registered request state and the array, so there
// is no combinational path from the address-phase inputs to the wait outputs.

// Per-port phase tracker: pending flag plus a wait-state down-counter.
module vscale_mem_phase #(
  parameter int WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,      // address phase valid this cycle
  output logic accept,   // address phase accepted at the coming edge
  output logic busy,     // data phase still stalling
  output logic done      // final data-phase cycle
);
  logic       pending;
  logic [3:0] cnt;

  assign busy   = pending && (cnt != 4'd0);
  assign done   = pending && (cnt == 4'd0);
  assign accept = !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      cnt     <= 4'd0;
    end else if (accept) begin
      pending <= req;
      cnt     <= 4'(WAIT);
    end else begin
      cnt     <= cnt - 4'd1;
    end
  end
endmodule

module vscale_mem_responder #(
  parameter int WORDS     = 1024,
  parameter int IMEM_WAIT = 0,
  parameter int DMEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_wait,
  output logic        imem_badmem_e,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef struct packed {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
  } dreq_t;

  logic [31:0] mem [WORDS];

  logic        i_acc, i_busy, i_done;
  logic        d_acc, d_busy, d_done;
  logic [31:0] imem_q;
  dreq_t       dreq_q;

  vscale_mem_phase #(.WAIT(IMEM_WAIT)) u_iph (
    .clk(clk), .reset(reset), .req(1'b1),
    .accept(i_acc), .busy(i_busy), .done(i_done)
  );

  vscale_mem_phase #(.WAIT(DMEM_WAIT)) u_dph (
    .clk(clk), .reset(reset), .req(dmem_en),
    .accept(d_acc), .busy(d_busy), .done(d_done)
  );

  // Request registers need no reset: the pending flags qualify them.
  always_ff @(posedge clk) begin
    if (i_acc) imem_q <= imem_addr;
    if (d_acc) dreq_q <= {dmem_wen, dmem_size, dmem_addr};
  end

  function automatic logic oob(input logic [31:0] a);
    return {2'b00, a[31:2]} >= 32'(WORDS);
  endfunction

  // ---------------- imem ----------------
  logic [AW-1:0] i_idx;
  logic          i_err;

  assign i_idx         = imem_q[AW+1:2];
  assign i_err         = oob(imem_q) || (imem_q[1:0] != 2'b00);
  assign imem_wait     = i_busy;
  assign imem_badmem_e = i_done && i_err;
  assign imem_rdata    = (i_done && !i_err) ? mem[i_idx] : 32'd0;

  // ---------------- dmem ----------------
  logic [AW-1:0] d_idx;
  logic          d_err, d_ok, d_we;
  logic [31:0]   d_word, d_sh, d_ld, d_wd;
  logic [15:0]   d_h;
  logic [7:0]    d_b;
  logic [3:0]    d_be;

  assign d_idx  = dreq_q.addr[AW+1:2];
  assign d_word = mem[d_idx];
  assign d_sh   = d_word >> {dreq_q.addr[1:0], 3'b000};
  assign d_b    = d_sh[7:0];
  assign d_h    = dreq_q.addr[1] ? d_word[31:16] : d_word[15:0];

  always_comb begin
    d_err = oob(dreq_q.addr);
    d_ld  = d_word;
    case (dreq_q.size)
      3'd0: d_ld = {{24{d_b[7]}}, d_b};
      3'd4: d_ld = {24'd0, d_b};
      3'd1: begin d_ld = {{16{d_h[15]}}, d_h}; d_err = d_err || dreq_q.addr[0]; end
      3'd5: begin d_ld = {16'd0, d_h};         d_err = d_err || dreq_q.addr[0]; end
      3'd2: d_err = d_err || (dreq_q.addr[1:0] != 2'b00);
      default: d_err = 1'b1;
    endcase
  end

  // Store lanes: size[1:0] selects B/H/W; the data is replicated so each
  // enabled lane picks its own copy.
  always_comb begin
    d_be = 4'b1111;
    d_wd = dmem_wdata_delayed;
    case (dreq_q.size[1:0])
      2'd0: begin
        d_be = 4'b0001 << dreq_q.addr[1:0];
        d_wd = {4{dmem_wdata_delayed[7:0]}};
      end
      2'd1: begin
        d_be = dreq_q.addr[1] ? 4'b1100 : 4'b0011;
        d_wd = {2{dmem_wdata_delayed[15:0]}};
      end
      default: ;
    endcase
  end

  assign d_ok          = d_done && !d_err;
  assign d_we          = d_ok && dreq_q.wen && !reset;  // reset discards an in-flight store
  assign dmem_wait     = d_busy;
  assign dmem_badmem_e = d_done && d_err;
  assign dmem_rdata    = (d_ok && !dreq_q.wen) ? d_ld : 32'd0;

  // Reads above see the pre-edge contents, giving read-before-write on collision.
  always_ff @(posedge clk) begin
    if (d_we)
      for (int k = 0; k < 4; k++)
        if (d_be[k]) mem[d_idx][8*k +: 8] <= d_wd[8*k +: 8];
  end
endmodule

// File: tb/tb_vscale_mem_responder.sv
// Directed bench for vscale_mem_responder. u_dut runs IMEM_WAIT=0/DMEM_WAIT=2
// for the main sequence; u_dut2 (DMEM_WAIT=3) shares the inputs but is held
// in reset until the final reset-during-store sequence.
module tb_vscale_mem_responder;
  localparam int WORDS = 1024;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [31:0] imem_addr;
  logic        dmem_en, dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed;

  logic [31:0] imem_rdata, dmem_rdata, u2_imem_rdata, u2_dmem_rdata;
  logic        imem_wait, imem_badmem_e, dmem_wait, dmem_badmem_e;
  logic        u2_imem_wait, u2_imem_badmem_e, u2_dmem_wait, u2_dmem_badmem_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vscale_mem_responder #(.WORDS(WORDS), .IMEM_WAIT(0), .DMEM_WAIT(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_wait(imem_wait),
    .imem_badmem_e(imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e)
  );

  vscale_mem_responder #(.WORDS(WORDS), .IMEM_WAIT(0), .DMEM_WAIT(3)) u_dut2 (
    .clk(clk), .reset(reset2),
    .imem_addr(imem_addr), .imem_rdata(u2_imem_rdata), .imem_wait(u2_imem_wait),
    .imem_badmem_e(u2_imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(u2_dmem_rdata), .dmem_wait(u2_dmem_wait),
    .dmem_badmem_e(u2_dmem_badmem_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One dmem access on u_dut (sel=0) or u_dut2 (sel=1). Returns the data,
  // error flag and imem_rdata seen in the final data-phase cycle, and the
  // number of wait cycles (-1 if the access never completed).
  task automatic dacc(input bit sel, input logic wen, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic bad, output int nw,
                      output logic [31:0] ird);
    logic done;
    done = 1'b0; nw = 0; rd = '0; bad = 1'b0; ird = '0;
    dmem_en = 1'b1; dmem_wen = wen; dmem_size = sz; dmem_addr = a;
    dmem_wdata_delayed = wd;
    step();
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sel ? u2_dmem_wait : dmem_wait) nw++;
      else begin
        rd   = sel ? u2_dmem_rdata : dmem_rdata;
        bad  = sel ? u2_dmem_badmem_e : dmem_badmem_e;
        ird  = sel ? u2_imem_rdata : imem_rdata;
        dmem_en = 1'b0; dmem_wen = 1'b0;
        done = 1'b1;
      end
      step();
    end
    dmem_en = 1'b0; dmem_wen = 1'b0;
    if (!done) nw = -1;
  endtask

  initial begin
    logic [31:0] rd, ird;
    logic        bad;
    int          nw;
    logic [31:0] pre [4];
    pre[0] = 32'h13; pre[1] = 32'h93; pre[2] = 32'h113; pre[3] = 32'h193;

    reset = 1'b1; reset2 = 1'b1; imem_addr = 32'd0;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = SZ_W; dmem_addr = 32'd0;
    dmem_wdata_delayed = 32'd0;
    step(); step();
    @(negedge clk);
    chk("reset_flags", {28'd0, imem_wait, imem_badmem_e, dmem_wait, dmem_badmem_e}, 32'd0);
    chk("reset_irdata", imem_rdata, 32'd0);
    chk("reset_drdata", dmem_rdata, 32'd0);
    reset = 1'b0;
    step();

    // Preload the fetch words through the store path.
    for (int i = 0; i < 4; i++) begin
      dacc(0, 1'b1, SZ_W, 32'(4*i), pre[i], rd, bad, nw, ird);
      chk("preload_bad", {31'd0, bad}, 32'd0);
    end

    // Back-to-back fetch.
    imem_addr = 32'd0;
    step();
    for (int i = 0; i < 4; i++) begin
      imem_addr = (i < 3) ? 32'(4*(i+1)) : 32'd0;
      @(negedge clk);
      chk("fetch_data", imem_rdata, pre[i]);
      chk("fetch_wait", {31'd0, imem_wait}, 32'd0);
      step();
    end

    // Word store/load with two wait states.
    dacc(0, 1'b1, SZ_W, 32'h40, 32'hDEADBEEF, rd, bad, nw, ird);
    chk("sw_waits", 32'(nw), 32'd2);
    chk("sw_bad", {31'd0, bad}, 32'd0);
    dacc(0, 1'b0, SZ_W, 32'h40, 32'd0, rd, bad, nw, ird);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_waits", 32'(nw), 32'd2);

    // Sub-word.
    dacc(0, 1'b1, SZ_B, 32'h41, 32'h00000080, rd, bad, nw, ird);
    chk("sb_bad", {31'd0, bad}, 32'd0);
    dacc(0, 1'b0, SZ_B, 32'h41, 32'd0, rd, bad, nw, ird);
    chk("lb", rd, 32'hFFFFFF80);
    dacc(0, 1'b0, SZ_BU, 32'h41, 32'd0, rd, bad, nw, ird);
    chk("lbu", rd, 32'h00000080);
    dacc(0, 1'b0, SZ_W, 32'h40, 32'd0, rd, bad, nw, ird);
    chk("lw_after_sb", rd, 32'hDEAD80EF);
    dacc(0, 1'b0, SZ_H, 32'h42, 32'd0, rd, bad, nw, ird);
    chk("lh_hi", rd, 32'hFFFFDEAD);

    // Errors.
    dacc(0, 1'b0, SZ_W, 32'h42, 32'd0, rd, bad, nw, ird);
    chk("lw_mis_bad", {31'd0, bad}, 32'd1);
    chk("lw_mis_rd", rd, 32'd0);
    dacc(0, 1'b0, SZ_H, 32'h43, 32'd0, rd, bad, nw, ird);
    chk("lh_mis_bad", {31'd0, bad}, 32'd1);
    chk("lh_mis_rd", rd, 32'd0);
    dacc(0, 1'b0, 3'd3, 32'h40, 32'd0, rd, bad, nw, ird);
    chk("sz3_bad", {31'd0, bad}, 32'd1);
    chk("sz3_rd", rd, 32'd0);
    dacc(0, 1'b1, SZ_W, 32'(4*WORDS), 32'hCAFEF00D, rd, bad, nw, ird);
    chk("sw_oob_bad", {31'd0, bad}, 32'd1);
    dacc(0, 1'b1, SZ_W, 32'h42, 32'h11111111, rd, bad, nw, ird);
    chk("sw_mis_bad", {31'd0, bad}, 32'd1);
    dacc(0, 1'b0, SZ_W, 32'h40, 32'd0, rd, bad, nw, ird);
    chk("lw_unchanged", rd, 32'hDEAD80EF);

    imem_addr = 32'h2;
    step();
    imem_addr = 32'(4*WORDS);
    @(negedge clk);
    chk("imem_mis_bad", {31'd0, imem_badmem_e}, 32'd1);
    chk("imem_mis_rd", imem_rdata, 32'd0);
    step();
    imem_addr = 32'd0;
    @(negedge clk);
    chk("imem_oob_bad", {31'd0, imem_badmem_e}, 32'd1);
    step();

    // Collision: store to word 0 while fetching word 0 every cycle.
    dacc(0, 1'b1, SZ_W, 32'h0, 32'h12345678, rd, bad, nw, ird);
    chk("coll_old", ird, 32'h13);
    @(negedge clk);
    chk("coll_new", imem_rdata, 32'h12345678);
    step();

    // Reset during cycle 2 of a DMEM_WAIT=3 store (u_dut2).
    reset2 = 1'b0;
    step();
    dacc(1, 1'b1, SZ_W, 32'h80, 32'hA5A5A5A5, rd, bad, nw, ird);
    chk("u2_sw_waits", 32'(nw), 32'd3);
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = SZ_W; dmem_addr = 32'h80;
    dmem_wdata_delayed = 32'h5A5A5A5A;
    step();
    @(negedge clk);
    chk("u2_dp1_wait", {31'd0, u2_dmem_wait}, 32'd1);
    step();
    reset2 = 1'b1;
    step();
    @(negedge clk);
    chk("u2_rst_flags", {28'd0, u2_imem_wait, u2_imem_badmem_e, u2_dmem_wait, u2_dmem_badmem_e}, 32'd0);
    chk("u2_rst_irdata", u2_imem_rdata, 32'd0);
    chk("u2_rst_drdata", u2_dmem_rdata, 32'd0);
    dmem_en = 1'b0; dmem_wen = 1'b0; reset2 = 1'b0;
    step();
    dacc(1, 1'b0, SZ_W, 32'h80, 32'd0, rd, bad, nw, ird);
    chk("u2_word_kept", rd, 32'hA5A5A5A5);
    chk("u2_lw_waits", 32'(nw), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
